// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit owning the HI/LO registers.
// Each operation takes a fixed 34 cycles: one accept cycle, 32 CALC iterations,
// one SIGN fix-up cycle, and then a one-cycle DONE pulse.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start, op         - launch request; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data, rt_data  - operands (multiplicand/multiplier or dividend/divisor)
//   hi_we, lo_we      - MTHI/MTLO write enables, with wdata
//   busy              - operation in progress (PC stall request)
//   done              - one-cycle pulse when HI/LO hold a new result
//   hi, lo            - architectural HI/LO registers
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W        = 32;
    localparam int unsigned CNT_W    = 6;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(31);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q;
    logic             div0_q;
    logic             neg_res_q;   // product / quotient must be negated
    logic             neg_rem_q;   // remainder takes the dividend's sign
    logic [W-1:0]     b_q;         // multiplicand or divisor magnitude
    logic [W-1:0]     acc_q;       // product upper half or partial remainder
    logic [W-1:0]     a_q;         // multiplier/product lower half or quotient
    logic [W-1:0]     rs_q;        // original dividend for divide-by-zero
    logic [W-1:0]     hi_q, lo_q;
    logic             busy_q, done_q;

    logic           signed_op, rs_neg, rt_neg;
    logic [W-1:0]   rs_abs, rt_abs;
    logic [W:0]     mul_sum;
    logic [W-1:0]   mul_acc_d, mul_a_d;
    logic [W:0]     div_sh;
    logic [W-1:0]   div_diff;
    logic           div_ge;
    logic [W-1:0]   div_acc_d, div_a_d;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix, rem_fix;

    // Operand magnitudes and one iteration of shift-add / restoring divide.
    always_comb begin
        signed_op = ~op[0];
        rs_neg    = signed_op & rs_data[W-1];
        rt_neg    = signed_op & rt_data[W-1];
        rs_abs    = rs_neg ? (~rs_data + W'(1)) : rs_data;
        rt_abs    = rt_neg ? (~rt_data + W'(1)) : rt_data;

        mul_sum   = a_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};
        mul_acc_d = mul_sum[W:1];
        mul_a_d   = {mul_sum[0], a_q[W-1:1]};

        // Shifted remainder always stays below twice the divisor, so the
        // 32-bit difference is exact whenever the trial subtract succeeds.
        div_sh    = {acc_q, a_q[W-1]};
        div_ge    = (div_sh >= {1'b0, b_q});
        div_diff  = div_sh[W-1:0] - b_q;
        div_acc_d = div_ge ? div_diff : div_sh[W-1:0];
        div_a_d   = {a_q[W-2:0], div_ge};

        prod_fix  = neg_res_q ? (~{acc_q, a_q} + (2*W)'(1)) : {acc_q, a_q};
        quot_fix  = neg_res_q ? (~a_q + W'(1)) : a_q;
        rem_fix   = neg_rem_q ? (~acc_q + W'(1)) : acc_q;
    end

    // Control FSM with datapath and HI/LO updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_q       <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            rs_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (start) begin
                        is_div_q  <= op[1];
                        div0_q    <= op[1] & (rt_data == '0);
                        neg_res_q <= rs_neg ^ rt_neg;
                        neg_rem_q <= rs_neg;
                        rs_q      <= rs_data;
                        acc_q     <= '0;
                        // Multiply: b=multiplicand, a=multiplier.
                        // Divide:   b=divisor,      a=dividend.
                        b_q       <= op[1] ? rt_abs : rs_abs;
                        a_q       <= op[1] ? rs_abs : rt_abs;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_CALC;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_q <= is_div_q ? div_acc_d : mul_acc_d;
                    a_q   <= is_div_q ? div_a_d : mul_a_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) state_q <= S_SIGN;
                end
                S_SIGN: begin
                    if (!is_div_q) begin
                        hi_q <= prod_fix[2*W-1:W];
                        lo_q <= prod_fix[W-1:0];
                    end else if (div0_q) begin
                        hi_q <= rs_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit, checked every cycle
// against a transaction-level model (plain 64-bit arithmetic plus a cycle
// countdown), and pinned with hand-computed literal results.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} straight from the arithmetic definition.
    function automatic logic [63:0] model_calc(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Model: m_cnt counts cycles since the accepted start (1..33 busy, 34 done).
    logic        m_started = 1'b0;
    logic        m_active;
    int          m_cnt;
    logic [31:0] m_hi, m_lo, m_rhi, m_rlo;

    always @(posedge clk) begin
        m_started = 1'b1;
        if (reset) begin
            m_active = 1'b0;
            m_cnt    = 0;
            m_hi     = 32'd0;
            m_lo     = 32'd0;
        end else if (!m_active || m_cnt == 34) begin
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
            if (start) begin
                {m_rhi, m_rlo} = model_calc(op, rs_data, rt_data);
                m_active = 1'b1;
                m_cnt    = 1;
            end else begin
                m_active = 1'b0;
                m_cnt    = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 34) begin
                m_hi = m_rhi;
                m_lo = m_rlo;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            chk("cyc busy", 32'(busy), 32'(m_active && m_cnt <= 33));
            chk("cyc done", 32'(done), 32'(m_active && m_cnt == 34));
            chk("cyc hi", hi, m_hi);
            chk("cyc lo", lo, m_lo);
        end
    end

    // Issues an op at the current negedge and waits (bounded) for done.
    // dist_cyc: cycle in which a stray DIVU start and MTHI are pulsed.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input string nm, input int dist_cyc);
        int  n    = 0;
        bit  seen = 1'b0;
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (c == dist_cyc) begin
                start = 1'b1;
                op    = 2'b11;
                hi_we = 1'b1;
                wdata = 32'hDEADBEEF;
            end
            if (c == dist_cyc + 1) begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                n    = c;
            end else begin
                @(negedge clk);
            end
        end
        chk({nm, " latency"}, 32'(n), 32'd34);
        chk({nm, " hi"}, hi, ehi);
        chk({nm, " lo"}, lo, elo);
    endtask

    initial begin
        int ndone;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = 32'd0;
        rt_data = 32'd0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult 7*-3", -5);
        @(negedge clk);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max", -5);
        // Back-to-back: next start issued in the DONE cycle.
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2", -5);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div ovf", -5);
        @(negedge clk);
        run_op(2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, "divu by 0", -5);
        @(negedge clk);
        run_op(2'b10, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 32'hFFFFFFFF, "div -100 by 0", -5);
        @(negedge clk);
        run_op(2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, "div -100/7", -5);
        @(negedge clk);

        // Stray start and MTHI while busy are ignored.
        run_op(2'b01, 32'd3, 32'd5, 32'h00000000, 32'h0000000F, "multu ignore", 10);
        @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'h00001234;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo lo", lo, 32'h00001234);
        chk("mtlo hi", hi, 32'h00000000);

        // MTHI coincident with an accepted start lands, then is overwritten.
        hi_we = 1'b1;
        wdata = 32'hAAAA5555;
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult mthi", -5);
        @(negedge clk);

        // Reset in cycle 20 of a DIV aborts the operation.
        start   = 1'b1;
        op      = 2'b10;
        rs_data = 32'hFFFFFF00;
        rt_data = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort no done", 32'(ndone), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the single-cycle MIPS datapath. Sits beside the ALU, downstream of the register file read ports (rs/rt data), and owns the architectural HI/LO registers consumed by MFHI/MFLO writeback. Executes MULT, MULTU, DIV and DIVU over a fixed 34-cycle latency. Raises `busy` so control can stall the PC until the result is ready.

## Interface
Parameters:
- none; datapath is fixed at 32 bits.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a new operation; sampled only in IDLE or DONE.
- `op` in 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data` in 32: multiplicand or dividend (ReadData1).
- `rt_data` in 32: multiplier or divisor (ReadData2).
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in 32: MTHI/MTLO data.
- `busy` out 1: operation in progress; PC stall request.
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE or DONE with `start`=1:
  - latch `op`, `rs_data`, `rt_data`;
  - for signed ops, latch absolute values and record result sign flags;
  - clear the 6-bit iteration counter; go to CALC.
- CALC, one iteration per cycle, 32 iterations (counter 0..31), then go to SIGN.
  - Multiply: shift-add on the 64-bit {acc, multiplier}. If the LSB is set, add the multiplicand to the upper half with a 33-bit carry, then shift right 1.
  - Divide: restoring division. Shift {rem, quot} left 1, trial-subtract the divisor from rem. If non-negative, keep the difference and set the quot LSB.
- SIGN: apply the sign fix-up, write HI/LO, go to DONE.
  - MULT: negate the 64-bit product if operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the sign of the dividend.
  - Writes: HI=product[63:32], LO=product[31:0]; or HI=remainder, LO=quotient.
- DONE: `done`=1 for this cycle only. Without a new `start`, go to IDLE.
- Divide by zero (DIV or DIVU): no exception. Result HI=rs (original signed value), LO=32'hFFFFFFFF, with the same latency.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Operand inputs are ignored after the start cycle.
- `start` in CALC or SIGN is ignored; it is neither queued nor restarted.
- MTHI/MTLO:
  - Applied at the clock edge only when state is IDLE or DONE; ignored in CALC/SIGN.
  - If coincident with an accepted `start`, the write still lands, and the operation result later overwrites it.
- HI/LO hold their value between operations.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
- Reset mid-operation aborts immediately: next cycle IDLE, HI/LO=0, no `done`.
- Cycle numbering: `start` accepted in cycle 0.
  - Cycles 1–32: CALC, `busy`=1.
  - Cycle 33: SIGN, `busy`=1.
  - Cycle 34: DONE, `busy`=0, `done`=1, HI/LO valid.
- Latency start to `done` is exactly 34 cycles for every op and operand value.
- `busy` and `done` are registered (state decode), never combinational from inputs.
- Back-to-back: `start` in cycle 34 (DONE) is accepted, and the next CALC begins in cycle 35.

## Test plan
- Signed multiply: MULT rs=7, rt=0xFFFFFFFD (-3), `start` in cycle 0.
  - `busy` high in cycles 1–33, `done` in cycle 34.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Unsigned multiply: MULTU rs=rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Signed divide: DIV rs=0xFFFFFFF9 (-7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide edge cases:
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 100 / 0 → HI=0x64, LO=0xFFFFFFFF, `done` in cycle 34.
- Ignored inputs while busy: MULTU 3×5 started.
  - In cycle 10, pulse `start` with op DIVU, and pulse `hi_we` with `wdata`=0xDEADBEEF.
  - Required: `done` still at cycle 34 with HI=0, LO=15.
  - Then MTLO 0x1234 in IDLE → LO=0x1234 next cycle.
- Reset abort: `reset` asserted in cycle 20 of a DIV.
  - Next cycle: `busy`=0, HI=LO=0.
  - No `done` pulse in the following 40 cycles.
